// File: rtl/sram_port_if.sv
// Master-side request/response bundle for the b16 external SRAM port.
interface sram_port_if #(
  parameter int unsigned DW    = 16,
  parameter int unsigned AW    = 18,
  parameter int unsigned BYTES = DW / 8
);
  logic             req;
  logic             r;
  logic [BYTES-1:0] w;
  logic [AW-1:0]    addr;
  logic [DW-1:0]    wdata;
  logic [DW-1:0]    rdata;
  logic             ack;
  logic             busy;

  modport master (
    output req, r, w, addr, wdata,
    input  rdata, ack, busy
  );

  modport slave (
    input  req, r, w, addr, wdata,
    output rdata, ack, busy
  );
endinterface

// File: rtl/sram_port.sv
// Handshaked asynchronous-SRAM controller: programmable read/write waits, write setup/hold
// phases and post-write bus turnaround. Every output comes straight from a flop.
module sram_port #(
  parameter int unsigned DW      = 16,
  parameter int unsigned AW      = 18,
  parameter int unsigned BYTES   = DW / 8,
  parameter int unsigned RD_WAIT = 1,
  parameter int unsigned WR_WAIT = 2,
  parameter int unsigned TURN    = 1
) (
  input  logic             clk,
  input  logic             reset,
  sram_port_if.slave       bus,
  output logic [AW-1:0]    sram_addr,
  input  logic [DW-1:0]    sram_dq_i,
  output logic [DW-1:0]    sram_dq_o,
  output logic             sram_dq_oe,
  output logic             sram_ce_n,
  output logic             sram_oe_n,
  output logic             sram_we_n,
  output logic [BYTES-1:0] sram_be_n
);

  localparam int unsigned MaxRw   = (RD_WAIT > WR_WAIT) ? RD_WAIT : WR_WAIT;
  localparam int unsigned MaxWait = (MaxRw > TURN) ? MaxRw : TURN;
  localparam int unsigned CW      = (MaxWait < 1) ? 1 : $clog2(MaxWait + 1);

  localparam logic [CW-1:0] RdLoad   = CW'(RD_WAIT);
  localparam logic [CW-1:0] WrLoad   = CW'(WR_WAIT);
  localparam logic [CW-1:0] TurnLoad = (TURN > 0) ? CW'(TURN - 1) : '0;

  typedef enum logic [2:0] {StIdle, StRead, StSetup, StPulse, StHold, StTurn} state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [DW-1:0]    rdata_q, rdata_d;
  logic             ack_q, ack_d;
  logic             busy_q, busy_d;
  logic [AW-1:0]    addr_q, addr_d;
  logic [DW-1:0]    dq_o_q, dq_o_d;
  logic             dq_oe_q, dq_oe_d;
  logic             ce_n_q, ce_n_d;
  logic             oe_n_q, oe_n_d;
  logic             we_n_q, we_n_d;
  logic [BYTES-1:0] be_n_q, be_n_d;

  // Outputs are computed for the state being entered, so strobes line up with that state.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    ack_d   = 1'b0;
    addr_d  = addr_q;
    dq_o_d  = dq_o_q;
    dq_oe_d = dq_oe_q;
    ce_n_d  = ce_n_q;
    oe_n_d  = oe_n_q;
    we_n_d  = we_n_q;
    be_n_d  = be_n_q;

    unique case (state_q)
      StIdle: begin
        if (bus.req) begin
          if (|bus.w) begin
            state_d = StSetup;
            addr_d  = bus.addr;
            dq_o_d  = bus.wdata;
            dq_oe_d = 1'b1;
            ce_n_d  = 1'b0;
            oe_n_d  = 1'b1;
            we_n_d  = 1'b1;
            be_n_d  = ~bus.w;
          end else if (bus.r) begin
            state_d = StRead;
            cnt_d   = RdLoad;
            addr_d  = bus.addr;
            dq_oe_d = 1'b0;
            ce_n_d  = 1'b0;
            oe_n_d  = 1'b0;
            we_n_d  = 1'b1;
            be_n_d  = '0;
          end else begin
            ack_d = 1'b1;
          end
        end
      end
      StRead: begin
        if (cnt_q == '0) begin
          state_d = StIdle;
          rdata_d = sram_dq_i;
          ack_d   = 1'b1;
          ce_n_d  = 1'b1;
          oe_n_d  = 1'b1;
          be_n_d  = '1;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      StSetup: begin
        state_d = StPulse;
        cnt_d   = WrLoad;
        we_n_d  = 1'b0;
      end
      StPulse: begin
        if (cnt_q == '0) begin
          state_d = StHold;
          we_n_d  = 1'b1;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      StHold: begin
        ack_d   = 1'b1;
        state_d = (TURN > 0) ? StTurn : StIdle;
        cnt_d   = TurnLoad;
        dq_oe_d = 1'b0;
        ce_n_d  = 1'b1;
        be_n_d  = '1;
      end
      StTurn: begin
        if (cnt_q == '0) begin
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      rdata_q <= '0;
      ack_q   <= 1'b0;
      busy_q  <= 1'b0;
      addr_q  <= '0;
      dq_o_q  <= '0;
      dq_oe_q <= 1'b0;
      ce_n_q  <= 1'b1;
      oe_n_q  <= 1'b1;
      we_n_q  <= 1'b1;
      be_n_q  <= '1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      ack_q   <= ack_d;
      busy_q  <= busy_d;
      addr_q  <= addr_d;
      dq_o_q  <= dq_o_d;
      dq_oe_q <= dq_oe_d;
      ce_n_q  <= ce_n_d;
      oe_n_q  <= oe_n_d;
      we_n_q  <= we_n_d;
      be_n_q  <= be_n_d;
    end
  end

  assign bus.rdata  = rdata_q;
  assign bus.ack    = ack_q;
  assign bus.busy   = busy_q;
  assign sram_addr  = addr_q;
  assign sram_dq_o  = dq_o_q;
  assign sram_dq_oe = dq_oe_q;
  assign sram_ce_n  = ce_n_q;
  assign sram_oe_n  = oe_n_q;
  assign sram_we_n  = we_n_q;
  assign sram_be_n  = be_n_q;

endmodule
